// File: rtl/tdm_demux_if.sv
// -----------------------------------------------------------------------------
// tdm_demux_if
// Bundles the serial input stream and the parallel frame output of the
// TDM demultiplexer.
//   din         serial data bit
//   din_valid   qualifies din and frame_start
//   frame_start marks din as bit 0 of a new frame
//   dout        last completed frame, channel k at dout[k*W +: W]
//   valid       one-cycle pulse, dout updated this cycle
//   sync_err    one-cycle pulse, partial frame aborted by early frame_start
// Modports: master drives the serial stream, slave is the demultiplexer.
// -----------------------------------------------------------------------------
interface tdm_demux_if #(
    parameter int N = 4,
    parameter int W = 8
);
    logic           din;
    logic           din_valid;
    logic           frame_start;
    logic [N*W-1:0] dout;
    logic           valid;
    logic           sync_err;

    modport master (
        output din, din_valid, frame_start,
        input  dout, valid, sync_err
    );

    modport slave (
        input  din, din_valid, frame_start,
        output dout, valid, sync_err
    );
endinterface

// File: rtl/tdm_demux.sv
// -----------------------------------------------------------------------------
// tdm_demux
// Receives a frame-synchronised serial bit stream (MSB of each channel first)
// and delivers N parallel W-bit channel words. The completed frame is written
// to dout atomically together with a one-cycle valid pulse; a frame_start that
// arrives before a frame is complete aborts it with a one-cycle sync_err pulse
// and starts a new frame with that bit.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous, active-high reset
//   bus  tdm_demux_if.slave (din, din_valid, frame_start, dout, valid, sync_err)
// -----------------------------------------------------------------------------
module tdm_demux #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic        clk,
    input  logic        rst,
    tdm_demux_if.slave  bus
);
    localparam int F  = N * W;
    localparam int CW = $clog2(F + 1);

    typedef enum logic {
        IDLE,
        RECV
    } state_t;

    state_t          state, state_next;
    logic [CW-1:0]   cnt, cnt_next;
    // Assembly register is a shift register: bit i of the frame ends up at
    // position F-1-i once all F bits have been shifted in.
    logic [F-1:0]    shift, shift_next;
    logic [F-1:0]    frame_word;
    logic            frame_done;
    logic            frame_abort;

    logic [F-1:0]    dout_q;
    logic            valid_q;
    logic            sync_err_q;

    // Next-state and datapath control.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_next  = state;
        cnt_next    = cnt;
        shift_next  = shift;
        frame_done  = 1'b0;
        frame_abort = 1'b0;

        if (bus.din_valid) begin
            unique case (state)
                IDLE: begin
                    if (bus.frame_start) begin
                        shift_next = {shift[F-2:0], bus.din};
                        cnt_next   = CW'(1);
                        state_next = RECV;
                    end
                end
                RECV: begin
                    shift_next = {shift[F-2:0], bus.din};
                    if (bus.frame_start) begin
                        // Early frame_start: this bit becomes bit 0 of a new frame.
                        frame_abort = 1'b1;
                        cnt_next    = CW'(1);
                    end else if (cnt == CW'(F - 1)) begin
                        frame_done = 1'b1;
                        cnt_next   = '0;
                        state_next = IDLE;
                    end else begin
                        cnt_next = cnt + CW'(1);
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Arrival order to channel layout: the first channel received sits in the
    // top W bits of the shift register, but belongs in dout[W-1:0].
    always_comb begin
        frame_word = '0;
        for (int c = 0; c < N; c++) begin
            frame_word[c*W +: W] = shift_next[(N-1-c)*W +: W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            // NOTE: the assembly register is cleared too so that the whole
            // block comes out of reset in a known state; functionally every
            // bit is overwritten before it reaches dout.
            shift      <= '0;
            dout_q     <= '0;
            valid_q    <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from the
            // values present before the edge.
            state      <= state_next;
            cnt        <= cnt_next;
            shift      <= shift_next;
            valid_q    <= frame_done;
            sync_err_q <= frame_abort;
            if (frame_done) begin
                dout_q <= frame_word;
            end
        end
    end

    assign bus.dout     = dout_q;
    assign bus.valid    = valid_q;
    assign bus.sync_err = sync_err_q;

endmodule

// File: tb/tb_tdm_demux.sv
// -----------------------------------------------------------------------------
// tb_tdm_demux
// Scoreboard bench for tdm_demux (N=4, W=8). A reference model keeps the bits
// of the current frame in a queue and, when an output event is due, pushes the
// expected event with the cycle in which it must appear. A monitor on the
// falling edge pops and compares events and checks that outputs stay quiet
// and dout holds its value in all other cycles.
// -----------------------------------------------------------------------------
module tb_tdm_demux;
    localparam int N = 4;
    localparam int W = 8;
    localparam int F = N * W;

    typedef enum {EV_VAL, EV_ERR, EV_RST} ev_kind_t;
    typedef struct {
        ev_kind_t     kind;
        logic [F-1:0] data;
        int           cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    tdm_demux_if #(.N(N), .W(W)) bus ();

    tdm_demux #(.N(N), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cycle  = 0;
    bit mon_en = 1'b0;

    always @(posedge clk) cycle++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cycle, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    ev_t          sb[$];
    bit           m_bits[$];
    bit           m_in_frame = 1'b0;
    logic [F-1:0] m_last = '0;

    function automatic logic [F-1:0] bits_to_word(input bit b[$]);
        logic [F-1:0] w;
        w = '0;
        for (int i = 0; i < F; i++) begin
            w[(i / W) * W + (W - 1 - (i % W))] = b[i];
        end
        return w;
    endfunction

    task automatic push_ev(input ev_kind_t k, input logic [F-1:0] d);
        ev_t e;
        e.kind = k;
        e.data = d;
        e.cyc  = cycle + 1;
        sb.push_back(e);
    endtask

    task automatic model_sample(input bit d, input bit fs);
        if (fs) begin
            if (m_in_frame) push_ev(EV_ERR, m_last);
            m_bits.delete();
            m_bits.push_back(d);
            m_in_frame = 1'b1;
        end else if (m_in_frame) begin
            m_bits.push_back(d);
            if (m_bits.size() == F) begin
                m_last = bits_to_word(m_bits);
                push_ev(EV_VAL, m_last);
                m_in_frame = 1'b0;
                m_bits.delete();
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step(input bit d, input bit dv, input bit fs);
        bus.din         = d;
        bus.din_valid   = dv;
        bus.frame_start = fs;
        if (dv) model_sample(d, fs);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        push_ev(EV_RST, '0);
        m_bits.delete();
        m_in_frame = 1'b0;
        m_last     = '0;
        bus.din         = 1'($urandom);
        bus.din_valid   = 1'b1;
        bus.frame_start = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send_frame(input logic [F-1:0] word, input bit stall);
        for (int i = 0; i < F; i++) begin
            if (stall) step(1'($urandom), 1'b0, 1'b1);
            step(word[(i / W) * W + (W - 1 - (i % W))], 1'b1, i == 0);
        end
    endtask

    // ---------------- monitor ----------------
    logic [F-1:0] held = '0;

    always @(negedge clk) begin
        ev_t          e;
        logic [63:0]  want;
        string        nm;
        if (mon_en) begin
            while (sb.size() > 0 && sb[0].cyc < cycle) begin
                e = sb.pop_front();
                check("missed_event", 64'(e.cyc), 64'(cycle));
            end
            want = 64'({1'b0, 1'b0, held});
            nm   = "quiet";
            if (sb.size() > 0 && sb[0].cyc == cycle) begin
                e = sb.pop_front();
                case (e.kind)
                    EV_VAL: begin
                        want = 64'({1'b1, 1'b0, e.data});
                        nm   = "valid_frame";
                        held = e.data;
                    end
                    EV_ERR: begin
                        want = 64'({1'b0, 1'b1, held});
                        nm   = "sync_err";
                    end
                    default: begin
                        want = 64'({1'b0, 1'b0, {F{1'b0}}});
                        nm   = "after_reset";
                        held = '0;
                    end
                endcase
            end
            check(nm, 64'({bus.valid, bus.sync_err, bus.dout}), want);
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        bus.din         = 1'b0;
        bus.din_valid   = 1'b0;
        bus.frame_start = 1'b0;
        @(posedge clk);
        #1;
        check("reset_dout", 64'(bus.dout), 64'(0));
        check("reset_valid", 64'(bus.valid), 64'(0));
        check("reset_sync_err", 64'(bus.sync_err), 64'(0));
        rst    = 1'b0;
        mon_en = 1'b1;

        // Idle noise: toggling din without frame_start is discarded.
        for (int i = 0; i < 100; i++) step(1'(i), 1'($urandom), 1'b0);

        // Basic frame.
        send_frame(32'h01FF3CA5, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("basic_dout", 64'(bus.dout), 64'h01FF3CA5);

        // Same frame with stalls carrying frame_start=1.
        apply_reset();
        send_frame(32'h01FF3CA5, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        check("stall_dout", 64'(bus.dout), 64'h01FF3CA5);

        // Back-to-back frames, second frame_start in the valid cycle.
        send_frame(32'h01FF3CA5, 1'b0);
        send_frame(32'h12345678, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("b2b_dout", 64'(bus.dout), 64'h12345678);

        // Abort after 10 bits, then a full frame.
        apply_reset();
        step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 9; i++) step(1'($urandom), 1'b1, 1'b0);
        send_frame(32'hDEADBEEF, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("abort_dout", 64'(bus.dout), 64'hDEADBEEF);

        // Reset after 20 bits, trailing bits without frame_start, new frame.
        step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 19; i++) step(1'($urandom), 1'b1, 1'b0);
        apply_reset();
        for (int i = 0; i < 40; i++) step(1'($urandom), 1'b1, 1'b0);
        send_frame(32'hCAFEF00D, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("post_reset_dout", 64'(bus.dout), 64'hCAFEF00D);

        // Randomized traffic with occasional aborts, stalls and resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 699) == 0) begin
                apply_reset();
            end else begin
                step(1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 44) == 0);
            end
        end
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
        check("scoreboard_drained", 64'(sb.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
